// File: rtl/spm_bank_serializer_pkg.sv
// Shared scratchpad definitions: lane/bank geometry, per-lane request record,
// serializer state encoding and the conflict-free issue helper.
package spm_bank_serializer_pkg;

    localparam int NUM_LANES  = 16;
    localparam int BANK_SEL_W = 4;
    localparam int BANK_OFF_W = 10;
    localparam int DATA_W     = 32;
    localparam int PERF_W     = 32;

    typedef struct packed {
        logic [BANK_SEL_W-1:0] bank;
        logic [BANK_OFF_W-1:0] offset;
    } sm_bank_address_t;

    typedef struct packed {
        logic [BANK_SEL_W-1:0] bank;
        logic [BANK_OFF_W-1:0] offset;
        logic [DATA_W-1:0]     wdata;
    } spm_lane_req_t;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_ISSUE = 1'b1
    } spm_serializer_state_t;

    // Lanes that may go to the crossbar this beat: pending and not blocked by a lower lane.
    function automatic logic [NUM_LANES-1:0] issue_subset(
        input logic [NUM_LANES-1:0] pending,
        input logic [NUM_LANES-1:0] conflicts
    );
        return pending & ~conflicts;
    endfunction

endpackage

// File: rtl/spm_serializer_ctrl.sv
// Serializer control: IDLE/ISSUE FSM, pending-lane register and optional
// performance counters (enabled by defining SPM_SERIALIZER_PERF_EN).
module spm_serializer_ctrl
    import spm_bank_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [NUM_LANES-1:0] in_mask,
    input  logic [NUM_LANES-1:0] cd_conflicts,
    input  logic                 out_ready,
    output logic                 in_ready,
    output logic                 in_accept,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [NUM_LANES-1:0] out_issue_mask,
    output logic [NUM_LANES-1:0] pending,
    output logic [PERF_W-1:0]    perf_req_cnt,
    output logic [PERF_W-1:0]    perf_beat_cnt,
    output logic [PERF_W-1:0]    perf_conf_cnt
);

    spm_serializer_state_t state_d, state_q;
    logic [NUM_LANES-1:0]  pending_d, pending_q;
    logic                  conflict_hit_s;

    assign pending        = pending_q;
    assign conflict_hit_s = |(pending_q & cd_conflicts);

    // Next-state, pending update and handshake outputs; everything is masked while reset is high.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        in_ready       = 1'b0;
        in_accept      = 1'b0;
        out_valid      = 1'b0;
        out_last       = 1'b0;
        out_issue_mask = {NUM_LANES{1'b0}};
        case (state_q)
            SER_IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    in_accept = 1'b1;
                    pending_d = in_mask;
                    state_d   = SER_ISSUE;
                end else begin
                    state_d = SER_IDLE;
                end
            end
            SER_ISSUE: begin
                if (!reset) begin
                    out_valid      = 1'b1;
                    out_issue_mask = issue_subset(pending_q, cd_conflicts);
                    out_last       = !conflict_hit_s;
                    if (out_ready) begin
                        // Only the lanes that lost arbitration remain for the next beat.
                        pending_d = pending_q & cd_conflicts;
                        if (!conflict_hit_s) begin
                            state_d = SER_IDLE;
                        end else begin
                            state_d = SER_ISSUE;
                        end
                    end else begin
                        pending_d = pending_q;
                    end
                end else begin
                    state_d = SER_ISSUE;
                end
            end
            default: begin
                state_d   = SER_IDLE;
                pending_d = {NUM_LANES{1'b0}};
            end
        endcase
    end

    // State and pending-mask registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SER_IDLE;
            pending_q <= {NUM_LANES{1'b0}};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef SPM_SERIALIZER_PERF_EN
    logic [PERF_W-1:0] req_cnt_d, req_cnt_q;
    logic [PERF_W-1:0] beat_cnt_d, beat_cnt_q;
    logic [PERF_W-1:0] conf_cnt_d, conf_cnt_q;
    logic              beat_fire_s;

    assign beat_fire_s   = out_valid && out_ready;
    assign perf_req_cnt  = req_cnt_q;
    assign perf_beat_cnt = beat_cnt_q;
    assign perf_conf_cnt = conf_cnt_q;

    // Counter increments; natural 32-bit wrap.
    always_comb begin
        req_cnt_d  = req_cnt_q;
        beat_cnt_d = beat_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (in_accept) begin
            req_cnt_d = req_cnt_q + 32'd1;
        end else begin
            req_cnt_d = req_cnt_q;
        end
        if (beat_fire_s) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            if (conflict_hit_s) begin
                conf_cnt_d = conf_cnt_q + 32'd1;
            end else begin
                conf_cnt_d = conf_cnt_q;
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_cnt_q  <= 32'd0;
            beat_cnt_q <= 32'd0;
            conf_cnt_q <= 32'd0;
        end else begin
            req_cnt_q  <= req_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end
`else
    assign perf_req_cnt  = 32'd0;
    assign perf_beat_cnt = 32'd0;
    assign perf_conf_cnt = 32'd0;
`endif

endmodule

// File: rtl/spm_bank_serializer.sv
// Scratchpad request serializer: latches one vector request and replays it as
// conflict-free beats using an external bank-conflict detector.
// Optional counters: define SPM_SERIALIZER_PERF_EN.
module spm_bank_serializer
    import spm_bank_serializer_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_LANES-1:0]             in_mask,
    input  logic [NUM_LANES*BANK_SEL_W-1:0]  in_bank,
    input  logic [NUM_LANES*BANK_OFF_W-1:0]  in_offset,
    input  logic [NUM_LANES*DATA_W-1:0]      in_wdata,
    input  logic                             in_is_store,
    output logic [NUM_LANES*BANK_SEL_W-1:0]  cd_bank,
    output logic [NUM_LANES-1:0]             cd_pending,
    input  logic [NUM_LANES-1:0]             cd_conflicts,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_LANES-1:0]             out_issue_mask,
    output logic [NUM_LANES*BANK_SEL_W-1:0]  out_bank,
    output logic [NUM_LANES*BANK_OFF_W-1:0]  out_offset,
    output logic [NUM_LANES*DATA_W-1:0]      out_wdata,
    output logic                             out_is_store,
    output logic                             out_last,
    output logic [PERF_W-1:0]                perf_req_cnt,
    output logic [PERF_W-1:0]                perf_beat_cnt,
    output logic [PERF_W-1:0]                perf_conf_cnt
);

    spm_lane_req_t [NUM_LANES-1:0] req_d, req_q;
    logic                          is_store_d, is_store_q;
    logic                          in_accept_s;
    logic [NUM_LANES-1:0]          pending_s;

    spm_serializer_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_mask        (in_mask),
        .cd_conflicts   (cd_conflicts),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .in_accept      (in_accept_s),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_issue_mask (out_issue_mask),
        .pending        (pending_s),
        .perf_req_cnt   (perf_req_cnt),
        .perf_beat_cnt  (perf_beat_cnt),
        .perf_conf_cnt  (perf_conf_cnt)
    );

    // Capture all per-lane fields on acceptance; hold them for the whole request.
    always_comb begin
        req_d      = req_q;
        is_store_d = is_store_q;
        if (in_accept_s) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                req_d[i].bank   = in_bank[i*BANK_SEL_W +: BANK_SEL_W];
                req_d[i].offset = in_offset[i*BANK_OFF_W +: BANK_OFF_W];
                req_d[i].wdata  = in_wdata[i*DATA_W +: DATA_W];
            end
            is_store_d = in_is_store;
        end else begin
            req_d      = req_q;
            is_store_d = is_store_q;
        end
    end

    // Request latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= '0;
            is_store_q <= 1'b0;
        end else begin
            req_q      <= req_d;
            is_store_q <= is_store_d;
        end
    end

    // Flatten the latched request back onto the crossbar and detector buses.
    always_comb begin
        out_bank   = {(NUM_LANES*BANK_SEL_W){1'b0}};
        out_offset = {(NUM_LANES*BANK_OFF_W){1'b0}};
        out_wdata  = {(NUM_LANES*DATA_W){1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            out_bank[i*BANK_SEL_W +: BANK_SEL_W]   = req_q[i].bank;
            out_offset[i*BANK_OFF_W +: BANK_OFF_W] = req_q[i].offset;
            out_wdata[i*DATA_W +: DATA_W]          = req_q[i].wdata;
        end
    end

    assign out_is_store = is_store_q;
    assign cd_bank      = out_bank;
    assign cd_pending   = pending_s;

endmodule

// File: tb/tb_spm_bank_serializer.sv
// Scoreboard bench for spm_bank_serializer with a behavioural conflict detector.
module tb_spm_bank_serializer;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_mask;
    logic [63:0]   in_bank;
    logic [159:0]  in_offset;
    logic [511:0]  in_wdata;
    logic          in_is_store;
    logic [63:0]   cd_bank;
    logic [15:0]   cd_pending;
    logic [15:0]   cd_conflicts;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_issue_mask;
    logic [63:0]   out_bank;
    logic [159:0]  out_offset;
    logic [511:0]  out_wdata;
    logic          out_is_store;
    logic          out_last;
    logic [31:0]   perf_req_cnt;
    logic [31:0]   perf_beat_cnt;
    logic [31:0]   perf_conf_cnt;

    spm_bank_serializer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .in_bank(in_bank), .in_offset(in_offset), .in_wdata(in_wdata),
        .in_is_store(in_is_store), .cd_bank(cd_bank), .cd_pending(cd_pending),
        .cd_conflicts(cd_conflicts), .out_valid(out_valid), .out_ready(out_ready),
        .out_issue_mask(out_issue_mask), .out_bank(out_bank), .out_offset(out_offset),
        .out_wdata(out_wdata), .out_is_store(out_is_store), .out_last(out_last),
        .perf_req_cnt(perf_req_cnt), .perf_beat_cnt(perf_beat_cnt), .perf_conf_cnt(perf_conf_cnt)
    );

    always #5 clk = ~clk;

    // Conflict detector model: a pending lane conflicts if a lower pending lane uses the same bank.
    always_comb begin
        cd_conflicts = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < i; j++) begin
                if (cd_pending[i] && cd_pending[j] && (cd_bank[i*4 +: 4] == cd_bank[j*4 +: 4]))
                    cd_conflicts[i] = 1'b1;
            end
        end
    end

    typedef struct {
        logic [15:0]  mask;
        logic         last;
        logic [511:0] wdata;
        logic [159:0] offset;
        logic         st;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Monitor: every handshaked beat is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: actual mask=%0h required=no beat", out_issue_mask);
            end else begin
                e = exp_q.pop_front();
                chk("beat_issue_mask", {48'd0, out_issue_mask}, {48'd0, e.mask});
                chk("beat_last", {63'd0, out_last}, {63'd0, e.last});
                chk("beat_is_store", {63'd0, out_is_store}, {63'd0, e.st});
                chk_w("beat_wdata", out_wdata, e.wdata);
                chk_w("beat_offset", {352'd0, out_offset}, {352'd0, e.offset});
            end
            hs_cnt++;
        end
    end

    function automatic logic [159:0] mk_off(input int seed);
        logic [159:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*10 +: 10] = 10'(seed * 37 + i * 3);
        return v;
    endfunction

    function automatic logic [511:0] mk_wd(input int seed);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'hA000_0000 + 32'(seed << 16) + 32'(i);
        return v;
    endfunction

    function automatic logic [63:0] banks_distinct();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = 4'(i);
        return v;
    endfunction

    function automatic logic [63:0] banks_all2();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = 4'd2;
        return v;
    endfunction

    // Lanes 0,4,8 on bank 5; lane 5 moved to the otherwise unused bank 0.
    function automatic logic [63:0] banks_t3();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = 4'(i);
        v[0*4 +: 4] = 4'd5;
        v[4*4 +: 4] = 4'd5;
        v[8*4 +: 4] = 4'd5;
        v[5*4 +: 4] = 4'd0;
        return v;
    endfunction

    task automatic push(input logic [15:0] m, input logic l, input int seed, input logic st);
        exp_t e;
        e.mask = m; e.last = l; e.wdata = mk_wd(seed); e.offset = mk_off(seed); e.st = st;
        exp_q.push_back(e);
    endtask

    // Present a request from posedge+1 until accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic [15:0] m, input logic [63:0] b, input int seed, input logic st);
        bit ok;
        in_mask = m; in_bank = b; in_offset = mk_off(seed); in_wdata = mk_wd(seed);
        in_is_store = st; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("request_accepted", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
            @(posedge clk);
            #1;
        end
        chk("request_completed", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_hs(input int target);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            if (hs_cnt >= target) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("handshake_reached", {63'd0, hit}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; in_mask = '0; in_bank = '0; in_offset = '0;
        in_wdata = '0; in_is_store = 1'b0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_cd_pending", {48'd0, cd_pending}, 64'd0);
        chk("idle_out_bank", out_bank, 64'd0);
        chk("idle_perf_beat", {32'd0, perf_beat_cnt}, 64'd0);
        @(posedge clk); #1;

        // 1: distinct banks, one beat in the cycle after acceptance
        push(16'hFFFF, 1'b1, 1, 1'b1);
        send(16'hFFFF, banks_distinct(), 1, 1'b1);
        @(negedge clk);
        chk("t1_first_beat_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_in_ready_busy", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        wait_done();

        // 2: all lanes on bank 2 -> 16 single-lane beats
        for (int k = 0; k < 16; k++) push(16'(1 << k), (k == 15), 2, 1'b0);
        send(16'hFFFF, banks_all2(), 2, 1'b0);
        wait_done();

        // 4: case 2 with a 3-cycle stall after beat 3
        base = hs_cnt;
        for (int k = 0; k < 16; k++) push(16'(1 << k), (k == 15), 4, 1'b1);
        send(16'hFFFF, banks_all2(), 4, 1'b1);
        wait_hs(base + 3);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_stall_valid", {63'd0, out_valid}, 64'd1);
            chk("t4_stall_mask", {48'd0, out_issue_mask}, 64'h0008);
            chk("t4_stall_pending", {48'd0, cd_pending}, 64'hFFF8);
            chk("t4_stall_last", {63'd0, out_last}, 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done();
        chk("t4_total_beats", 64'(hs_cnt - base), 64'd16);

        // 5a: empty mask -> single empty last beat
        push(16'h0000, 1'b1, 5, 1'b0);
        send(16'h0000, banks_distinct(), 5, 1'b0);
        wait_done();

        // 5b: reset while beat 5 of an all-bank-2 request is offered
        base = hs_cnt;
        for (int k = 0; k < 4; k++) push(16'(1 << k), 1'b0, 6, 1'b1);
        send(16'hFFFF, banks_all2(), 6, 1'b1);
        wait_hs(base + 4);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rst_out_last", {63'd0, out_last}, 64'd0);
        chk("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t5_rst_issue_mask", {48'd0, out_issue_mask}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_post_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t5_post_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_post_pending", {48'd0, cd_pending}, 64'd0);
        chk("t5_queue_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // 3: lanes 0,4,8 share bank 5
        push(16'hFEEF, 1'b0, 3, 1'b1);
        push(16'h0010, 1'b0, 3, 1'b1);
        push(16'h0100, 1'b1, 3, 1'b1);
        send(16'hFFFF, banks_t3(), 3, 1'b1);
        wait_done();

        // 6: counters after case 3 (counters cleared by the reset in 5b)
`ifdef SPM_SERIALIZER_PERF_EN
        chk("perf_req", {32'd0, perf_req_cnt}, 64'd1);
        chk("perf_beat", {32'd0, perf_beat_cnt}, 64'd3);
        chk("perf_conf", {32'd0, perf_conf_cnt}, 64'd2);
`else
        chk("perf_req", {32'd0, perf_req_cnt}, 64'd0);
        chk("perf_beat", {32'd0, perf_beat_cnt}, 64'd0);
        chk("perf_conf", {32'd0, perf_conf_cnt}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
